// File: rtl/unified_mem_arbiter.sv
// Arbitrates one shared single-port memory between an instruction-fetch port and a
// load/store port. Data normally wins; a bounded starvation counter guarantees fetch progress.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_valid_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_valid_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       starved;
  logic       fetch_win;
  logic       data_win;

  // Fetch only beats a pending data request once data has had LIMIT grants in a row.
  assign starved   = (starve_cnt == LIMIT);
  assign fetch_win = if_req_i & (~d_req_i | starved);
  assign data_win  = d_req_i & ~fetch_win;

  assign stall_if_o  = if_req_i & ~if_valid_o;
  assign stall_mem_o = d_req_i & ~d_valid_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      if_valid_o  <= 1'b0;
      d_valid_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      d_valid_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req_i) starve_cnt <= '0;
          // An ack with nothing outstanding is a protocol violation: flag it, grant nothing.
          if (mem_ack_i) begin
            err_o <= 1'b1;
          end else if (fetch_win) begin
            state      <= IF_BUSY;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= if_addr_i;
            starve_cnt <= '0;
          end else if (data_win) begin
            state       <= D_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            if (if_req_i && !starved) starve_cnt <= starve_cnt + 3'd1;
          end
        end
        IF_BUSY: begin
          if (mem_ack_i) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            if_valid_o <= 1'b1;
            if_rdata_o <= mem_rdata_i;
          end
        end
        D_BUSY: begin
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            d_valid_o <= 1'b1;
            if (!mem_we_o) d_rdata_o <= mem_rdata_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a 3-cycle-latency memory model plus
// hand-computed expectations for fetch, store, arbitration, starvation, error and reset.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_valid_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        err_o;

  logic        model_ack;
  logic        spur_ack;
  logic [31:0] model_rdata;

  int total = 0;
  int bad   = 0;
  int if_vcnt = 0;
  int d_vcnt  = 0;
  int stab_err = 0;
  logic gq[$];

  logic        prev_req = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  always #5 clk = ~clk;

  assign mem_ack_i   = model_ack | spur_ack;
  assign mem_rdata_i = model_rdata;

  unified_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_valid_o  (if_valid_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_valid_o   (d_valid_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_if_o  (stall_if_o),
    .stall_mem_o (stall_mem_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_valid(input bit fetch, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = fetch ? if_valid_o : d_valid_o;
    end
  endtask

  // Memory: ack three cycles after it first sees the request; rdata derived from the address.
  initial begin
    int wcnt;
    wcnt = 0;
    model_ack = 1'b0;
    model_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (model_ack) begin
        model_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req_o) begin
        wcnt++;
        if (wcnt == 3) begin
          model_ack = 1'b1;
          model_rdata = (mem_addr_o == 32'h100) ? 32'h13 : mem_addr_o + 32'h1000_0000;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: valid pulse counts, grant order (1 = fetch) and request stability.
  initial begin
    forever begin
      @(negedge clk);
      if (if_valid_o) if_vcnt++;
      if (d_valid_o) d_vcnt++;
      if (mem_req_o && !prev_req) gq.push_back(mem_addr_o == if_addr_i);
      if (mem_req_o && prev_req &&
          (mem_addr_o != prev_addr || mem_wdata_o != prev_wdata || mem_we_o != prev_we))
        stab_err++;
      prev_req = mem_req_o;
      prev_we = mem_we_o;
      prev_addr = mem_addr_o;
      prev_wdata = mem_wdata_o;
    end
  end

  initial begin
    bit seen;
    bit d_done;
    bit i_done;
    int stall_bad;
    int snap_if;
    int snap_d;
    logic [9:0] pat;

    rst = 1'b0;
    if_req_i = 1'b0;
    if_addr_i = '0;
    d_req_i = 1'b0;
    d_we_i = 1'b0;
    d_addr_i = '0;
    d_wdata_i = '0;
    spur_ack = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    chk("rst_mem_we", 32'(mem_we_o), 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_if_valid", 32'(if_valid_o), 0);
    chk("rst_d_valid", 32'(d_valid_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    rst = 1'b1;

    // Fetch only
    @(negedge clk);
    if_addr_i = 32'h100;
    if_req_i = 1'b1;
    #1 chk("fetch_stall_pre", 32'(stall_if_o), 1);
    @(negedge clk);
    chk("fetch_mem_req", 32'(mem_req_o), 1);
    chk("fetch_mem_we", 32'(mem_we_o), 0);
    chk("fetch_mem_addr", mem_addr_o, 32'h100);
    seen = 1'b0;
    stall_bad = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (if_valid_o) seen = 1'b1;
      else if (!stall_if_o) stall_bad++;
    end
    chk("fetch_valid_seen", 32'(seen), 1);
    chk("fetch_stall_at_valid", 32'(stall_if_o), 0);
    chk("fetch_rdata", if_rdata_o, 32'h13);
    chk("fetch_stall_held", stall_bad, 0);
    if_req_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("fetch_one_pulse", if_vcnt, 1);
    chk("fetch_mem_idle", 32'(mem_req_o), 0);

    // Store
    d_we_i = 1'b1;
    d_addr_i = 32'h40;
    d_wdata_i = 32'hDEAD_BEEF;
    d_req_i = 1'b1;
    @(negedge clk);
    chk("store_mem_req", 32'(mem_req_o), 1);
    chk("store_mem_we", 32'(mem_we_o), 1);
    chk("store_mem_addr", mem_addr_o, 32'h40);
    chk("store_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    wait_valid(1'b0, seen);
    d_req_i = 1'b0;
    d_we_i = 1'b0;
    chk("store_valid_seen", 32'(seen), 1);
    chk("store_rdata_held", d_rdata_o, 0);
    repeat (3) @(negedge clk);
    chk("store_one_pulse", d_vcnt, 1);

    // Simultaneous fetch and load: data first
    gq.delete();
    if_addr_i = 32'h300;
    d_addr_i = 32'h2000;
    if_req_i = 1'b1;
    d_req_i = 1'b1;
    d_done = 1'b0;
    i_done = 1'b0;
    for (int i = 0; i < 80 && !(d_done && i_done); i++) begin
      @(negedge clk);
      if (d_valid_o) begin d_req_i = 1'b0; d_done = 1'b1; end
      if (if_valid_o) begin if_req_i = 1'b0; i_done = 1'b1; end
    end
    repeat (3) @(negedge clk);
    chk("sim_grants", gq.size(), 2);
    if (gq.size() >= 2) begin
      chk("sim_first_data", 32'(gq[0]), 0);
      chk("sim_second_fetch", 32'(gq[1]), 1);
    end
    chk("sim_d_pulses", d_vcnt, 2);
    chk("sim_if_pulses", if_vcnt, 2);
    chk("sim_d_rdata", d_rdata_o, 32'h1000_2000);
    chk("sim_if_rdata", if_rdata_o, 32'h1000_0300);

    // Starvation: both held, expect D D D D F D D D D F
    gq.delete();
    if_req_i = 1'b1;
    d_req_i = 1'b1;
    for (int i = 0; i < 300 && gq.size() < 10; i++) @(negedge clk);
    if_req_i = 1'b0;
    d_req_i = 1'b0;
    repeat (12) @(negedge clk);
    chk("starve_grants", gq.size(), 10);
    pat = '0;
    for (int i = 0; i < 10 && i < gq.size(); i++) pat = {pat[8:0], gq[i]};
    chk("starve_pattern", 32'(pat), 32'h021);
    chk("starve_if_pulses", if_vcnt, 4);
    chk("starve_d_pulses", d_vcnt, 10);

    // Requester drops mid-transaction; access still completes
    d_addr_i = 32'h80;
    d_req_i = 1'b1;
    @(negedge clk);
    d_req_i = 1'b0;
    wait_valid(1'b0, seen);
    chk("drop_valid_seen", 32'(seen), 1);
    chk("drop_rdata", d_rdata_o, 32'h1000_0080);
    repeat (2) @(negedge clk);

    // Spurious ack in IDLE
    snap_if = if_vcnt;
    snap_d = d_vcnt;
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    chk("spur_err_set", 32'(err_o), 1);
    repeat (3) @(negedge clk);
    chk("spur_err_sticky", 32'(err_o), 1);
    chk("spur_mem_idle", 32'(mem_req_o), 0);
    chk("spur_no_if_pulse", if_vcnt, snap_if);
    chk("spur_no_d_pulse", d_vcnt, snap_d);
    rst = 1'b0;
    #1 chk("spur_err_cleared", 32'(err_o), 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset during D_BUSY
    d_addr_i = 32'h2000;
    d_we_i = 1'b0;
    d_req_i = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_req", 32'(mem_req_o), 1);
    snap_d = d_vcnt;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rstmid_async_drop", 32'(mem_req_o), 0);
    repeat (2) @(negedge clk);
    d_req_i = 1'b0;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_no_pulse", d_vcnt, snap_d);
    chk("rstmid_idle", 32'(mem_req_o), 0);
    chk("req_stable", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while fetch waits (range 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 if_req_i  input  1  fetch request, level; held with if_addr_i stable until if_valid_o.
REQ-005 if_addr_i  input  32  fetch address.
REQ-006 if_rdata_o  output  32  fetch read data, valid with if_valid_o.
REQ-007 if_valid_o  output  1  one-cycle fetch completion pulse.
REQ-008 d_req_i  input  1  data request, level; held with d_we_i, d_addr_i and d_wdata_i stable until d_valid_o.
REQ-009 d_we_i  input  1  1 = store, 0 = load.
REQ-010 d_addr_i / d_wdata_i  input  32 / 32  data address / store data.
REQ-011 d_rdata_o  output  32  load data, valid with d_valid_o.
REQ-012 d_valid_o  output  1  one-cycle data completion pulse (loads and stores).
REQ-013 mem_req_o / mem_we_o  output  1 / 1  shared memory request / write enable.
REQ-014 mem_addr_o / mem_wdata_o  output  32 / 32  shared memory address / write data.
REQ-015 mem_ack_i / mem_rdata_i  input  1 / 32  memory completion; read data valid in the ack cycle.
REQ-016 stall_if_o / stall_mem_o  output  1 / 1  pipeline stall requests toward the stall controller.
REQ-017 err_o  output  1  sticky protocol error flag.

Function
REQ-018 FSM states: IDLE, IF_BUSY, D_BUSY. State, mem_*, *_rdata_o, *_valid_o and err_o are registered.
REQ-019 IDLE, only if_req_i high: go to IF_BUSY next edge; mem_req_o=1, mem_we_o=0, mem_addr_o=if_addr_i.
REQ-020 IDLE, only d_req_i high: go to D_BUSY; mem_req_o=1, mem_we_o=d_we_i, mem_addr_o=d_addr_i, mem_wdata_o=d_wdata_i.
REQ-021 IDLE, both high: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-022 starve_cnt (3 bit): increments on each data grant made while if_req_i high, saturating at STARVE_LIMIT; clears on fetch grant or whenever if_req_i is low in IDLE.
REQ-023 BUSY states: mem_req_o and the address, write enable and write data are held stable until mem_ack_i is sampled high.
REQ-024 Ack edge: mem_req_o=0; FSM returns to IDLE; the owner's valid_o pulses one cycle. Load/fetch rdata_o captures mem_rdata_i; rdata_o otherwise holds its value.
REQ-025 No back-to-back issue: the next grant is decided in the IDLE cycle after the ack, so a request can issue no earlier than 2 cycles after the previous ack.
REQ-026 Minimum latency: request seen in IDLE at edge N gives mem_req_o high after N; ack sampled at edge N+1 gives valid_o high after N+1.
REQ-027 stall_if_o = if_req_i & ~if_valid_o; stall_mem_o = d_req_i & ~d_valid_o (combinational).
REQ-028 A requester that drops req mid-transaction does not abort it: the memory access completes and valid_o still pulses.
REQ-029 mem_ack_i high in IDLE sets err_o; it is then ignored, with no valid pulse and no state change. err_o clears only on reset.
REQ-030 A request still high in the valid_o cycle is treated as a new request at that IDLE edge.

Reset
REQ-031 rst low asynchronously forces: state IDLE; mem_req_o, mem_we_o, if_valid_o, d_valid_o and err_o to 0; mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o and starve_cnt to 0.
REQ-032 Reset during BUSY abandons the transaction with no valid pulse. After rst rises, the first grant is evaluated at the next rising edge.

Verification
REQ-033 Fetch only: if_addr_i=0x100, mem_rdata_i=0x00000013, ack 3 cycles after mem_req_o -> one if_valid_o pulse, if_rdata_o=0x13, stall_if_o high until that pulse.
REQ-034 Simultaneous: if_req_i and d_req_i (load 0x2000) both high in IDLE -> data served first, then fetch; exactly one valid pulse each.
REQ-035 Starvation, STARVE_LIMIT=4: d_req_i and if_req_i held high -> 4 data grants, then 1 fetch grant, pattern repeats.
REQ-036 Store: d_we_i=1, d_addr_i=0x40, d_wdata_i=0xDEADBEEF -> mem_we_o=1 with stable address and data until ack; d_valid_o pulses; d_rdata_o unchanged.
REQ-037 Spurious ack: mem_ack_i=1 in IDLE -> err_o=1 and stays 1; no valid pulse. Reset clears it to 0.
REQ-038 Reset mid-access: rst low while in D_BUSY -> mem_req_o=0 with no clock edge; no d_valid_o after rst rises.
